// File: rtl/uc_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
package uc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } uc_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_FUNCT = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;

  typedef struct packed {
    logic is_r;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_addi;
    logic is_j;
    logic illegal;
  } uc_dec_t;

endpackage

// File: rtl/uc_op_decode.sv
// Combinational opcode classifier for the multicycle control unit.
module uc_op_decode
  import uc_pkg::*;
#(
  parameter int unsigned OP_W = 6
) (
  input  logic [OP_W-1:0] i_op,
  output uc_dec_t         o_dec
);

  always_comb begin
    o_dec = '0;
    case (i_op)
      OP_W'(OP_RTYPE): o_dec.is_r    = 1'b1;
      OP_W'(OP_LW):    o_dec.is_lw   = 1'b1;
      OP_W'(OP_SW):    o_dec.is_sw   = 1'b1;
      OP_W'(OP_BEQ):   o_dec.is_beq  = 1'b1;
      OP_W'(OP_ADDI):  o_dec.is_addi = 1'b1;
      OP_W'(OP_J):     o_dec.is_j    = 1'b1;
      default:         o_dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memory
// wait states and illegal-opcode trap. Define UC_PERF_CNT_EN for the retired-instruction counter.
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  output logic               RegWrite,
  output logic               MemtoReg,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IorD,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               RegDst,
  output logic               ALUSrc,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               trap,
  output logic               busy,
  output logic [CNT_W-1:0]   instr_cnt
);

  uc_state_t       r_state;
  uc_state_t       w_next;
  uc_state_t       w_boundary;
  logic [OP_W-1:0] r_op_q;
  logic [OP_W-1:0] w_dec_op;
  logic [2:0]      w_alu_code;
  uc_dec_t         w_dec;

  // One decoder serves both the live IR opcode (in DECODE) and the latched op_q.
  assign w_dec_op = (r_state == S_DECODE) ? op : r_op_q;

  uc_op_decode #(.OP_W(OP_W)) u_dec (
    .i_op  (w_dec_op),
    .o_dec (w_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op_q  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op_q <= op;
    end
  end

  assign w_boundary = en ? S_FETCH : S_IDLE;
  assign busy       = (r_state != S_IDLE);
  assign ALUop      = ALUOP_W'(w_alu_code);

  always_comb begin
    w_next      = r_state;
    w_alu_code  = ALU_ADD;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    RegDst      = 1'b0;
    ALUSrc      = 1'b0;
    trap        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) w_next = S_FETCH;
      end
      S_FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_dec.illegal) begin
          w_next = S_TRAP;
        end else if (w_dec.is_j) begin
          PCWrite = 1'b1;
          w_next  = w_boundary;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_dec.is_r) begin
          w_alu_code = ALU_FUNCT;
          w_next     = S_WB;
        end else if (w_dec.is_lw || w_dec.is_sw || w_dec.is_addi) begin
          ALUSrc = 1'b1;
          w_next = w_dec.is_addi ? S_WB : S_MEM;
        end else if (w_dec.is_beq) begin
          w_alu_code  = ALU_SUB;
          PCWriteCond = 1'b1;
          w_next      = w_boundary;
        end else begin
          w_next = S_TRAP;
        end
      end
      S_MEM: begin
        IorD     = 1'b1;
        MemRead  = w_dec.is_lw;
        MemWrite = w_dec.is_sw;
        if (mem_ready) w_next = w_dec.is_lw ? S_WB : w_boundary;
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemtoReg = w_dec.is_lw;
        RegDst   = w_dec.is_r;
        w_next   = w_boundary;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

`ifdef UC_PERF_CNT_EN
  logic             w_retire;
  logic [CNT_W-1:0] r_instr_cnt;

  // Retirement points: J leaving DECODE, BEQ leaving EXEC, SW leaving MEM, the rest leaving WB.
  assign w_retire = ((r_state == S_DECODE) && w_dec.is_j)
                 || ((r_state == S_EXEC)   && w_dec.is_beq)
                 || ((r_state == S_MEM)    && w_dec.is_sw && mem_ready)
                 ||  (r_state == S_WB);

  always_ff @(posedge clk) begin
    if (!rst_n)        r_instr_cnt <= '0;
    else if (w_retire) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
  end

  assign instr_cnt = r_instr_cnt;
`else
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_uc_multiciclo.sv
// Table-driven bench for uc_multiciclo plus hand sequences for counter wrap and LW wait latency.
module tb_uc_multiciclo;

  logic       clk = 1'b0;
  logic       rst_n, en, mem_ready;
  logic [5:0] op;
  logic       RegWrite, MemtoReg, MemRead, MemWrite, IorD, IRWrite;
  logic       PCWrite, PCWriteCond, RegDst, ALUSrc, trap, busy;
  logic [2:0] ALUop;
  logic [3:0] instr_cnt;

  always #5 clk = ~clk;

  uc_multiciclo #(.OP_W(6), .ALUOP_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .mem_ready(mem_ready),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemRead(MemRead), .MemWrite(MemWrite),
    .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUop(ALUop), .trap(trap), .busy(busy),
    .instr_cnt(instr_cnt)
  );

  // Output vector order: RW M2R MR MW IorD IRW PCW PCWC RD AS ALU[2:0] trap busy
  localparam logic [14:0] B_RW   = 15'd1 << 14;
  localparam logic [14:0] B_M2R  = 15'd1 << 13;
  localparam logic [14:0] B_MR   = 15'd1 << 12;
  localparam logic [14:0] B_MW   = 15'd1 << 11;
  localparam logic [14:0] B_IORD = 15'd1 << 10;
  localparam logic [14:0] B_IRW  = 15'd1 << 9;
  localparam logic [14:0] B_PCW  = 15'd1 << 8;
  localparam logic [14:0] B_PCWC = 15'd1 << 7;
  localparam logic [14:0] B_RD   = 15'd1 << 6;
  localparam logic [14:0] B_AS   = 15'd1 << 5;
  localparam logic [14:0] A_FUN  = 15'd1 << 2;
  localparam logic [14:0] A_SUB  = 15'd2 << 2;
  localparam logic [14:0] B_TRAP = 15'd1 << 1;
  localparam logic [14:0] B_BUSY = 15'd1;

  localparam logic [14:0] E_IDLE   = '0;
  localparam logic [14:0] E_F_WAIT = B_MR | B_BUSY;
  localparam logic [14:0] E_F_RDY  = B_MR | B_IRW | B_PCW | B_BUSY;
  localparam logic [14:0] E_DEC    = B_BUSY;
  localparam logic [14:0] E_DEC_J  = B_PCW | B_BUSY;
  localparam logic [14:0] E_EX_R   = A_FUN | B_BUSY;
  localparam logic [14:0] E_EX_AS  = B_AS | B_BUSY;
  localparam logic [14:0] E_EX_BEQ = A_SUB | B_PCWC | B_BUSY;
  localparam logic [14:0] E_MEM_LW = B_MR | B_IORD | B_BUSY;
  localparam logic [14:0] E_MEM_SW = B_MW | B_IORD | B_BUSY;
  localparam logic [14:0] E_WB_R   = B_RW | B_RD | B_BUSY;
  localparam logic [14:0] E_WB_LW  = B_RW | B_M2R | B_BUSY;
  localparam logic [14:0] E_WB_AI  = B_RW | B_BUSY;
  localparam logic [14:0] E_TRAP   = B_TRAP | B_BUSY;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [5:0]  op;
    logic        mr;
    logic [14:0] exp;
    int          cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic add(input logic r, input logic e, input logic [5:0] o, input logic m,
                     input logic [14:0] x, input int c);
    vec_t v;
    v.rst_n = r; v.en = e; v.op = o; v.mr = m; v.exp = x; v.cnt = c;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [14:0] exp, input int c);
    logic [14:0] got;
    logic [3:0]  ecnt;
    got = {RegWrite, MemtoReg, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
           RegDst, ALUSrc, ALUop, trap, busy};
`ifdef UC_PERF_CNT_EN
    ecnt = c[3:0];
`else
    ecnt = '0;
`endif
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s outputs: got %b want %b", nm, got, exp);
    end
    n_vec++;
    if (instr_cnt !== ecnt) begin
      n_fail++;
      $display("FAIL %s instr_cnt: got %0d want %0d", nm, instr_cnt, ecnt);
    end
    n_vec++;
    if (MemRead && MemWrite) begin
      n_fail++;
      $display("FAIL %s memexcl: got MemRead=1 MemWrite=1 want at most one", nm);
    end
  endtask

  task automatic step(input string nm, input logic r, input logic e, input logic [5:0] o,
                      input logic m, input logic [14:0] x, input int c);
    @(negedge clk);
    rst_n = r; en = e; op = o; mem_ready = m;
    #1;
    check(nm, x, c);
  endtask

  initial begin
    int lat, wcnt;
    bit done, saw_m2r;

    rst_n = 1'b0; en = 1'b0; op = 6'h00; mem_ready = 1'b1;
    repeat (2) @(posedge clk);

    add(1,0,6'h00,1,E_IDLE,0);
    // R-type
    add(1,1,6'h00,1,E_IDLE,0);
    add(1,1,6'h00,1,E_F_RDY,0);
    add(1,1,6'h00,1,E_DEC,0);
    add(1,1,6'h3F,1,E_EX_R,0);
    add(1,1,6'h3F,1,E_WB_R,0);
    // LW with one fetch wait and three memory waits
    add(1,1,6'h00,0,E_F_WAIT,1);
    add(1,1,6'h00,1,E_F_RDY,1);
    add(1,1,6'h23,1,E_DEC,1);
    add(1,1,6'h3F,1,E_EX_AS,1);
    add(1,1,6'h3F,0,E_MEM_LW,1);
    add(1,1,6'h3F,0,E_MEM_LW,1);
    add(1,1,6'h3F,0,E_MEM_LW,1);
    add(1,1,6'h3F,1,E_MEM_LW,1);
    add(1,1,6'h3F,1,E_WB_LW,1);
    // SW
    add(1,1,6'h00,1,E_F_RDY,2);
    add(1,1,6'h2B,1,E_DEC,2);
    add(1,1,6'h3F,1,E_EX_AS,2);
    add(1,1,6'h3F,1,E_MEM_SW,2);
    // ADDI
    add(1,1,6'h00,1,E_F_RDY,3);
    add(1,1,6'h08,1,E_DEC,3);
    add(1,1,6'h3F,1,E_EX_AS,3);
    add(1,1,6'h3F,1,E_WB_AI,3);
    // J
    add(1,1,6'h00,1,E_F_RDY,4);
    add(1,1,6'h02,1,E_DEC_J,4);
    // BEQ with en dropped in EXEC
    add(1,1,6'h00,1,E_F_RDY,5);
    add(1,1,6'h04,1,E_DEC,5);
    add(1,0,6'h3F,1,E_EX_BEQ,5);
    add(1,0,6'h00,1,E_IDLE,6);
    // Illegal opcode trap, held with en=1, then reset
    add(1,1,6'h00,1,E_IDLE,6);
    add(1,1,6'h00,1,E_F_RDY,6);
    add(1,1,6'h3F,1,E_DEC,6);
    for (int i = 0; i < 10; i++) add(1,1,6'h00,1,E_TRAP,6);
    add(0,1,6'h00,1,E_TRAP,6);
    add(1,0,6'h00,1,E_IDLE,0);
    // Reset during SW memory wait
    add(1,1,6'h00,1,E_IDLE,0);
    add(1,1,6'h00,1,E_F_RDY,0);
    add(1,1,6'h2B,1,E_DEC,0);
    add(1,1,6'h3F,1,E_EX_AS,0);
    add(1,1,6'h3F,0,E_MEM_SW,0);
    add(0,1,6'h3F,0,E_MEM_SW,0);
    add(1,0,6'h3F,0,E_IDLE,0);

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].en, vecs[i].op, vecs[i].mr,
           vecs[i].exp, vecs[i].cnt);

    // Back-to-back J: 17 retirements wrap a 4-bit counter to 1
    step("jidle", 1, 1, 6'h02, 1, E_IDLE, 0);
    for (int k = 0; k < 17; k++) begin
      step($sformatf("jf%0d", k), 1, 1, 6'h02, 1, E_F_RDY, k);
      step($sformatf("jd%0d", k), 1, (k == 16) ? 1'b0 : 1'b1, 6'h02, 1, E_DEC_J, k);
    end
    step("jend", 1, 0, 6'h00, 1, E_IDLE, 17);

    // LW from IDLE with three memory wait cycles: busy for 8 cycles
    step("lwidle", 1, 1, 6'h23, 1, E_IDLE, 17);
    lat = 0; wcnt = 0; done = 1'b0; saw_m2r = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      en = 1'b0; op = 6'h23; mem_ready = 1'b1;
      #1;
      if (IorD && wcnt < 3) begin
        mem_ready = 1'b0;
        wcnt++;
      end
      #1;
      if (MemtoReg) saw_m2r = 1'b1;
      if (busy) lat++;
      else done = 1'b1;
    end
    n_vec++;
    if (!done) begin
      n_fail++;
      $display("FAIL lw_timeout: got busy after 50 cycles want idle");
    end
    n_vec++;
    if (lat != 8) begin
      n_fail++;
      $display("FAIL lw_latency: got %0d want 8", lat);
    end
    n_vec++;
    if (!saw_m2r) begin
      n_fail++;
      $display("FAIL lw_memtoreg: got 0 want 1");
    end
    check("lwdone", E_IDLE, 18);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
